// File: rtl/util_axis_packetizer.sv
// util_axis_packetizer: cuts an AXI-stream into fixed-length packets behind one output register stage.
// Define UTIL_AXIS_PACKETIZER_PAD_EN to zero-pad short frames up to the packet length instead of truncating them.
module util_axis_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    output logic                  short_pkt
);
`ifdef UTIL_AXIS_PACKETIZER_PAD_EN
    typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;
`else
    typedef enum logic {IDLE, PASS} state_t;
`endif
    localparam logic [LEN_WIDTH:0] ONE = 1;
    state_t state, state_nx;
    logic [LEN_WIDTH:0] len_q, len_nx, beat_cnt, cnt_nx, len_cur, cnt_inc;
    logic out_adv, in_pad, accept, emit, done, early, last_nx;
    logic [DATA_WIDTH-1:0] data_nx;
`ifdef UTIL_AXIS_PACKETIZER_PAD_EN
    assign in_pad = state == PAD;
`else
    assign in_pad = 1'b0;
`endif
    assign out_adv      = ~m_axis_valid | m_axis_ready;
    assign s_axis_ready = ~reset & out_adv & ~in_pad;
    assign accept       = s_axis_valid & s_axis_ready;
    // Length is captured only on the first beat, so later pkt_len changes cannot disturb an open packet.
    assign len_cur = state == IDLE ? {1'b0, pkt_len} + ONE : len_q;
    assign cnt_inc = state == IDLE ? ONE : beat_cnt + ONE;
    assign done    = cnt_inc == len_cur;
    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        cnt_nx   = beat_cnt;
        emit     = 1'b0;
        data_nx  = s_axis_data;
        last_nx  = 1'b0;
        early    = 1'b0;
        if (accept) begin
            emit   = 1'b1;
            len_nx = len_cur;
            cnt_nx = cnt_inc;
            early  = ~done & s_axis_last;
`ifdef UTIL_AXIS_PACKETIZER_PAD_EN
            last_nx  = done;
            state_nx = done ? IDLE : early ? PAD : PASS;
`else
            last_nx  = done | early;
            state_nx = done | early ? IDLE : PASS;
`endif
        end
`ifdef UTIL_AXIS_PACKETIZER_PAD_EN
        else if (in_pad && out_adv) begin
            emit     = 1'b1;
            data_nx  = '0;
            cnt_nx   = cnt_inc;
            last_nx  = done;
            state_nx = done ? IDLE : PAD;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len_q        <= '0;
            beat_cnt     <= '0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            short_pkt    <= 1'b0;
        end else begin
            state     <= state_nx;
            len_q     <= len_nx;
            beat_cnt  <= cnt_nx;
            short_pkt <= early;
            if (out_adv) begin
                m_axis_valid <= emit;
                if (emit) begin
                    m_axis_data <= data_nx;
                    m_axis_last <= last_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_util_axis_packetizer.sv
// tb_util_axis_packetizer: randomized bench with a queue-based packet model of util_axis_packetizer.
// The model follows UTIL_AXIS_PACKETIZER_PAD_EN the same way the design does.
module tb_util_axis_packetizer;
    localparam int DW = 32;
    localparam int LW = 16;
`ifdef UTIL_AXIS_PACKETIZER_PAD_EN
    localparam bit PAD_MODE = 1'b1;
`else
    localparam bit PAD_MODE = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic [LW-1:0] pkt_len = '0;
    logic s_axis_valid = 1'b0, s_axis_last = 1'b0, m_axis_ready = 1'b1;
    logic s_axis_ready, m_axis_valid, m_axis_last, short_pkt;
    logic [DW-1:0] s_axis_data = '0, m_axis_data;

    util_axis_packetizer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .pkt_len(pkt_len),
        .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
        .s_axis_data(s_axis_data), .s_axis_last(s_axis_last),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_last(m_axis_last),
        .short_pkt(short_pkt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] d; logic l; bit pad;} beat_t;
    beat_t q[$];
    int vectors = 0, miscompares = 0;
    int pos = 0, n_cur = 0, pad_left = 0, out_beats = 0, last_cnt = 0, short_seen = 0;
    int rmode = 0;
    bit gap_en = 1'b0, short_due = 1'b0, lat_due = 1'b0, hold_due = 1'b0;
    logic [DW-1:0] lat_data, hold_data;
    logic hold_last;

    function automatic beat_t mk(input logic [DW-1:0] d, input logic l, input bit p);
        beat_t b;
        b.d = d; b.l = l; b.pad = p;
        return b;
    endfunction

    initial forever begin
        @(posedge clk); #1;
        m_axis_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_axis_ready : 1'($urandom_range(0, 1));
    end

    // Scoreboard: all signals are stable at the falling edge, so the handshakes seen here are the ones the next rising edge will take.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            pos = 0; pad_left = 0;
            short_due = 0; lat_due = 0; hold_due = 0;
        end else begin
            vectors++;
            if (short_pkt !== short_due) begin
                miscompares++;
                $display("FAIL short_pkt got=%b exp=%b t=%0t", short_pkt, short_due, $time);
            end
            if (short_pkt) short_seen++;
            if (lat_due) begin
                vectors++;
                if (m_axis_valid !== 1'b1 || m_axis_data !== lat_data) begin
                    miscompares++;
                    $display("FAIL latency got valid=%b data=%h exp valid=1 data=%h", m_axis_valid, m_axis_data, lat_data);
                end
            end
            if (hold_due) begin
                vectors++;
                if (m_axis_valid !== 1'b1 || m_axis_data !== hold_data || m_axis_last !== hold_last) begin
                    miscompares++;
                    $display("FAIL hold got v=%b d=%h l=%b exp v=1 d=%h l=%b", m_axis_valid, m_axis_data, m_axis_last, hold_data, hold_last);
                end
            end
            if (pad_left >= 2) begin
                vectors++;
                if (s_axis_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pad_ready got=%b exp=0", s_axis_ready);
                end
            end
            short_due = 0;
            lat_due = 0;
            hold_due = m_axis_valid && !m_axis_ready;
            hold_data = m_axis_data;
            hold_last = m_axis_last;
            if (m_axis_valid && m_axis_ready) begin
                out_beats++;
                if (m_axis_last) last_cnt++;
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_beat unexpected d=%h l=%b exp none", m_axis_data, m_axis_last);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    if (e.pad) pad_left--;
                    if (m_axis_data !== e.d || m_axis_last !== e.l) begin
                        miscompares++;
                        $display("FAIL out_beat got d=%h l=%b exp d=%h l=%b", m_axis_data, m_axis_last, e.d, e.l);
                    end
                end
            end
            if (s_axis_valid && s_axis_ready) begin
                lat_due = 1;
                lat_data = s_axis_data;
                if (pos == 0) n_cur = int'(pkt_len) + 1;
                pos++;
                if (pos == n_cur) begin
                    q.push_back(mk(s_axis_data, 1'b1, 1'b0));
                    pos = 0;
                end else if (s_axis_last) begin
                    short_due = 1;
                    if (PAD_MODE) begin
                        q.push_back(mk(s_axis_data, 1'b0, 1'b0));
                        for (int k = pos + 1; k <= n_cur; k++) begin
                            q.push_back(mk('0, k == n_cur, 1'b1));
                            pad_left++;
                        end
                    end else begin
                        q.push_back(mk(s_axis_data, 1'b1, 1'b0));
                    end
                    pos = 0;
                end else begin
                    q.push_back(mk(s_axis_data, 1'b0, 1'b0));
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        if (gap_en && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        s_axis_valid = 1'b1; s_axis_data = d; s_axis_last = l;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (s_axis_ready) break;
            if (t >= 500) begin
                vectors++; miscompares++;
                $display("FAIL send_beat_timeout ready=%b exp=1", s_axis_ready);
                break;
            end
        end
        @(posedge clk); #1;
        s_axis_valid = 1'b0; s_axis_last = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !m_axis_valid) break;
        end
        vectors++;
        if (q.size() != 0 || m_axis_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain pending=%0d valid=%b exp pending=0 valid=0", q.size(), m_axis_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_counts(input string name, input int d_out, input int e_out, input int d_last, input int e_last);
        vectors++;
        if (d_out != e_out || d_last != e_last) begin
            miscompares++;
            $display("FAIL %s got beats=%0d lasts=%0d exp beats=%0d lasts=%0d", name, d_out, d_last, e_out, e_last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({m_axis_valid, m_axis_data, m_axis_last, short_pkt, s_axis_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b d=%h l=%b s=%b r=%b exp all 0", m_axis_valid, m_axis_data, m_axis_last, short_pkt, s_axis_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (s_axis_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset got=%b exp=1", s_axis_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        int o0, l0;
        rmode = 0; gap_en = 1; pkt_len = 16'd3;
        o0 = out_beats; l0 = last_cnt;
        for (int i = 1; i <= 8; i++) send_beat(DW'(i), 1'b0);
        drain();
        check_counts("normal", out_beats - o0, 8, last_cnt - l0, 2);
    endtask

    task automatic test_backpressure();
        int o0, l0;
        rmode = 1; gap_en = 0; pkt_len = 16'd1;
        o0 = out_beats; l0 = last_cnt;
        for (int i = 0; i < 8; i++) send_beat($urandom, 1'b0);
        drain();
        check_counts("backpressure", out_beats - o0, 8, last_cnt - l0, 4);
    endtask

    task automatic test_early_end();
        int o0, l0, s0;
        rmode = 0; gap_en = 0; pkt_len = 16'd4;
        o0 = out_beats; l0 = last_cnt; s0 = short_seen;
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b1);
        drain();
        check_counts("early_end", out_beats - o0, PAD_MODE ? 5 : 2, last_cnt - l0, 1);
        vectors++;
        if (short_seen - s0 != 1) begin
            miscompares++;
            $display("FAIL early_short got=%0d exp=1", short_seen - s0);
        end
        o0 = out_beats; l0 = last_cnt;
        for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0);
        drain();
        check_counts("after_early", out_beats - o0, 5, last_cnt - l0, 1);
    endtask

    task automatic test_boundary();
        int o0, l0, s0;
        rmode = 0; gap_en = 1; pkt_len = 16'd0;
        o0 = out_beats; l0 = last_cnt; s0 = short_seen;
        for (int i = 0; i < 6; i++) send_beat($urandom, 1'($urandom_range(0, 1)));
        drain();
        check_counts("len1", out_beats - o0, 6, last_cnt - l0, 6);
        pkt_len = 16'd2;
        for (int i = 0; i < 3; i++) send_beat($urandom, i == 2);
        drain();
        vectors++;
        if (short_seen - s0 != 0) begin
            miscompares++;
            $display("FAIL last_at_n_short got=%0d exp=0", short_seen - s0);
        end
        gap_en = 0; pkt_len = 16'hFFFF;
        o0 = out_beats; l0 = last_cnt;
        for (int i = 0; i < 65536; i++) send_beat($urandom, 1'b0);
        drain();
        check_counts("len65536", out_beats - o0, 65536, last_cnt - l0, 1);
    endtask

    task automatic test_reset_mid();
        int o0, l0;
        rmode = 0; gap_en = 0; pkt_len = 16'd3;
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({m_axis_valid, m_axis_data, m_axis_last, short_pkt, s_axis_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got v=%b d=%h l=%b s=%b r=%b exp all 0", m_axis_valid, m_axis_data, m_axis_last, short_pkt, s_axis_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        o0 = out_beats; l0 = last_cnt;
        for (int i = 0; i < 4; i++) send_beat($urandom, 1'b0);
        drain();
        check_counts("after_reset", out_beats - o0, 4, last_cnt - l0, 1);
    endtask

    task automatic test_random();
        rmode = 2; gap_en = 1;
        for (int i = 0; i < 400; i++) begin
            pkt_len = LW'($urandom_range(0, 5));
            send_beat($urandom, $urandom_range(0, 5) == 0);
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_early_end();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/util_axis_packetizer.md
UTIL_AXIS_PACKETIZER -- requirements
Module: util_axis_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the data bus in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of the packet-length input in bits.
REQ-003 SHALL have port clk  input  1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port pkt_len  input  LEN_WIDTH: packet length minus one, in beats.
REQ-006 SHALL have port s_axis_valid  input  1: upstream beat valid.
REQ-007 SHALL have port s_axis_ready  output  1: upstream beat accepted when this and s_axis_valid are both high.
REQ-008 SHALL have port s_axis_data  input  DATA_WIDTH: upstream data.
REQ-009 SHALL have port s_axis_last  input  1: upstream end-of-frame marker.
REQ-010 SHALL have port m_axis_valid  output  1: downstream beat valid (feeds util_axis_buf).
REQ-011 SHALL have port m_axis_ready  input  1: downstream ready.
REQ-012 SHALL have port m_axis_data  output  DATA_WIDTH: downstream data.
REQ-013 SHALL have port m_axis_last  output  1: asserted high on the final beat of each packet.
REQ-014 SHALL have port short_pkt  output  1: one-cycle pulse, set when an upstream frame ended before the full packet length.

Function
REQ-015 SHALL provide a single output register stage.
  - m_axis_valid, m_axis_data and m_axis_last come from flops.
  - s_axis_ready = ~m_axis_valid | m_axis_ready, and is forced to 0 in PAD.
REQ-016 SHALL have a latency of 1 cycle: an accepted beat appears on m_axis the next cycle.
REQ-017 SHALL hold m_axis_data and m_axis_last stable while m_axis_valid=1 and m_axis_ready=0.
REQ-018 SHALL have the states IDLE (no packet open), PASS (packet open) and PAD (only with the macro of REQ-030).
REQ-019 SHALL, on an accepted beat in IDLE:
  - latch N = pkt_len+1 into len_q, a LEN_WIDTH+1 bit register, so that pkt_len = all-ones gives 2^LEN_WIDTH beats without overflow;
  - set beat_cnt = 1;
  - go to PASS, unless N = 1.
REQ-020 SHALL NOT let changes of pkt_len affect a packet that is already open.
REQ-021 SHALL increment beat_cnt (LEN_WIDTH+1 bits) on each accepted beat in PASS.
REQ-022 SHALL, on the accepted beat where beat_cnt reaches N:
  - drive m_axis_last=1 on that output beat;
  - return to IDLE;
  - ignore s_axis_last (no short_pkt).
  This also covers the N = 1 case.
REQ-023 SHALL, on an accepted beat with s_axis_last=1 before the count reaches N, act according to the macro of REQ-030 and pulse short_pkt for 1 cycle, in the cycle after acceptance.
REQ-024 SHALL, when s_axis_last=1 and the count reaches N on the same beat, treat the beat as a normal end (REQ-022).
REQ-025 SHALL NOT, in PAD, pad while m_axis_ready=0: the counter and state stay frozen.

Reset
REQ-026 SHALL clear all state while reset=1, regardless of an open packet or a pending output:
  - state = IDLE;
  - m_axis_valid=0, m_axis_data=0, m_axis_last=0, short_pkt=0;
  - beat_cnt=0, len_q=0.
REQ-027 SHALL drive s_axis_ready=0 while reset=1.
REQ-028 SHALL drive s_axis_ready=1 in the first cycle after reset is released.
REQ-029 SHALL discard any partial packet when reset asserts mid-operation; no last beat is emitted for it.

Configuration
REQ-030 SHALL provide the macro UTIL_AXIS_PACKETIZER_PAD_EN.
  - Defined: an early s_axis_last beat is output with m_axis_last=0 and the state goes to PAD. PAD emits all-zero data beats until the count reaches N, with m_axis_last=1 on the Nth beat, then returns to IDLE.
  - Undefined: the PAD state and its logic are absent. An early s_axis_last beat is output with m_axis_last=1 and the state returns to IDLE, so the packet is truncated.

Verification
REQ-031 SHALL cover a normal packet: pkt_len=3, 8 beats 0x1..0x8, m_axis_ready=1 -> last on 0x4 and 0x8; no short_pkt; 1-cycle latency.
REQ-032 SHALL cover backpressure: pkt_len=1, m_axis_ready toggling 1/0 each cycle -> no beat lost or duplicated; data held while stalled; last on every 2nd beat.
REQ-033 SHALL cover an early end without the macro: pkt_len=4, s_axis_last on beat 2 -> 2 beats out, last on beat 2, short_pkt 1 cycle; the next packet starts with beat_cnt=1.
REQ-034 SHALL cover an early end with the macro: same stimulus as REQ-033 -> beats D1, D2, 0, 0, 0; last on beat 5; s_axis_ready=0 for the 3 pad beats.
REQ-035 SHALL cover boundary lengths:
  - pkt_len=0 -> last on every beat;
  - pkt_len=0xFFFF -> last on beat 65536 only;
  - s_axis_last coinciding with beat N -> no short_pkt.
REQ-036 SHALL cover reset mid-packet: reset on beat 2 of a 4-beat packet -> all outputs 0 next cycle; the next packet is a full 4 beats.
